// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } mreq_t;

  localparam logic [2:0] MSIZE_WORD = 3'd2;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one 64-bit memory port between fetch and data buses, data first
// Optional MEM_ARB_STARVE_EN: after STARVE_LIMIT data grants with fetch waiting, fetch is forced.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RESET_PC_UNUSED = 0,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mresp_ready,
  input  logic [63:0] mresp_data
);

  if (RESET_PC_UNUSED != 0) begin : g_bad_reset_pc
    $error("mem_arbiter: RESET_PC_UNUSED is reserved and must be 0");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_state_t state;
  mreq_t      mreq;
  logic       abort;
  logic       grant_d;
  logic       grant_i;
  logic       force_i;

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_i = ireq_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts data grants that overtook a waiting fetch; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!ireq_valid || grant_i) starve_cnt <= '0;
      else if (grant_d)           starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  assign grant_d = (state == IDLE) && dreq_valid && !force_i;
  assign grant_i = (state == IDLE) && ireq_valid && !grant_d;

  assign mreq_valid  = mreq.valid;
  assign mreq_addr   = mreq.addr;
  assign mreq_size   = mreq.size;
  assign mreq_strobe = mreq.strobe;
  assign mreq_data   = mreq.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mreq          <= '0;
      abort         <= 1'b0;
      iresp_data_ok <= 1'b0;
      iresp_data    <= '0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= '0;
    end else begin
      iresp_data_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      unique case (state)
        IDLE: begin
          abort <= 1'b0;
          if (grant_d) begin
            mreq  <= '{valid: 1'b1, addr: dreq_addr, size: dreq_size,
                       strobe: dreq_strobe, data: dreq_data};
            state <= BUSY_D;
          end else if (grant_i) begin
            mreq  <= '{valid: 1'b1, addr: ireq_addr, size: MSIZE_WORD,
                       strobe: 8'h00, data: 64'h0};
            state <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (mresp_ready) begin
            // A flushed fetch still drains from memory but its word is never delivered.
            mreq.valid    <= 1'b0;
            state         <= IDLE;
            abort         <= 1'b0;
            iresp_data_ok <= ireq_valid && !abort;
            iresp_data    <= mreq.addr[2] ? mresp_data[63:32] : mresp_data[31:0];
          end else if (!ireq_valid) begin
            abort <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mresp_ready) begin
            mreq.valid    <= 1'b0;
            state         <= IDLE;
            dresp_data_ok <= 1'b1;
            dresp_data    <= mresp_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_ready;
  logic [63:0] mresp_data;

  mem_arbiter #(.RESET_PC_UNUSED(0), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_ready(mresp_ready), .mresp_data(mresp_data)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] D_ADDR = 64'h8000_1000;

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic        mr;
    logic [63:0] md;
    logic        e_mv;
    logic [63:0] e_ma;
    logic        e_iok;
    logic [31:0] e_id;
    logic        e_dok;
    logic [63:0] e_dd;
  } vec_t;

  vec_t vecs[24];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic       order_d[6];
    logic       exp_d[6];
    logic       prev_v;
    int         grants;

    // fetch, simultaneous I+D, flush, IDLE response, flush with re-assert + latched addr
    vecs[0]  = '{1, 64'h8000_0004, 0, 0, 64'h0, 1, 64'h8000_0004, 0, 32'h0, 0, 64'h0};
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = '{1, 64'h8000_0004, 0, 1, 64'h1111_2222_3333_4444, 0, 64'h8000_0004, 1, 32'h1111_2222, 0, 64'h0};
    vecs[4]  = '{0, 64'h0, 0, 0, 64'h0, 0, 64'h8000_0004, 0, 32'h0, 0, 64'h0};
    vecs[5]  = '{1, 64'h8000_0008, 1, 0, 64'h0, 1, D_ADDR, 0, 32'h0, 0, 64'h0};
    vecs[6]  = vecs[5];
    vecs[7]  = '{1, 64'h8000_0008, 1, 1, 64'hCAFE, 0, D_ADDR, 0, 32'h0, 1, 64'hCAFE};
    vecs[8]  = '{1, 64'h8000_0008, 0, 0, 64'h0, 1, 64'h8000_0008, 0, 32'h0, 0, 64'h0};
    vecs[9]  = '{1, 64'h8000_0008, 0, 1, 64'hAAAA_AAAA_BBBB_BBBB, 0, 64'h8000_0008, 1, 32'hBBBB_BBBB, 0, 64'h0};
    vecs[10] = '{0, 64'h0, 0, 0, 64'h0, 0, 64'h8000_0008, 0, 32'h0, 0, 64'h0};
    vecs[11] = '{1, 64'h8000_0010, 0, 0, 64'h0, 1, 64'h8000_0010, 0, 32'h0, 0, 64'h0};
    vecs[12] = '{0, 64'h0, 0, 0, 64'h0, 1, 64'h8000_0010, 0, 32'h0, 0, 64'h0};
    vecs[13] = '{0, 64'h0, 0, 1, 64'h123, 0, 64'h8000_0010, 0, 32'h0, 0, 64'h0};
    vecs[14] = '{1, 64'h8000_0014, 0, 0, 64'h0, 1, 64'h8000_0014, 0, 32'h0, 0, 64'h0};
    vecs[15] = '{1, 64'h8000_0014, 0, 1, 64'h5555_6666_7777_8888, 0, 64'h8000_0014, 1, 32'h5555_6666, 0, 64'h0};
    vecs[16] = '{0, 64'h0, 0, 1, 64'h999, 0, 64'h8000_0014, 0, 32'h0, 0, 64'h0};
    vecs[17] = '{1, 64'h8000_0018, 0, 0, 64'h0, 1, 64'h8000_0018, 0, 32'h0, 0, 64'h0};
    vecs[18] = '{0, 64'h0, 0, 0, 64'h0, 1, 64'h8000_0018, 0, 32'h0, 0, 64'h0};
    vecs[19] = '{1, 64'h8000_0020, 0, 0, 64'h0, 1, 64'h8000_0018, 0, 32'h0, 0, 64'h0};
    vecs[20] = '{1, 64'h8000_0020, 0, 1, 64'hFFFF_0000_EEEE_1111, 0, 64'h8000_0018, 0, 32'h0, 0, 64'h0};
    vecs[21] = '{1, 64'h8000_0020, 0, 0, 64'h0, 1, 64'h8000_0020, 0, 32'h0, 0, 64'h0};
    vecs[22] = '{1, 64'h8000_0020, 0, 1, 64'h0102_0304_0506_0708, 0, 64'h8000_0020, 1, 32'h0506_0708, 0, 64'h0};
    vecs[23] = '{0, 64'h0, 0, 0, 64'h0, 0, 64'h8000_0020, 0, 32'h0, 0, 64'h0};

    reset = 1'b1;
    ireq_valid = 0; ireq_addr = '0;
    dreq_valid = 0; dreq_addr = D_ADDR; dreq_size = 3'd3; dreq_strobe = 8'hFF; dreq_data = 64'hDEAD;
    mresp_ready = 0; mresp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mreq_valid", mreq_valid, 0);
    chk("reset mreq_addr", mreq_addr, 0);
    chk("reset iresp_data_ok", iresp_data_ok, 0);
    chk("reset dresp_data_ok", dresp_data_ok, 0);
    chk("reset dresp_data", dresp_data, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      ireq_valid = vecs[i].iv; ireq_addr = vecs[i].ia;
      dreq_valid = vecs[i].dv;
      mresp_ready = vecs[i].mr; mresp_data = vecs[i].md;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mreq_valid", i), mreq_valid, vecs[i].e_mv);
      chk($sformatf("v%0d mreq_addr", i), mreq_addr, vecs[i].e_ma);
      chk($sformatf("v%0d iresp_data_ok", i), iresp_data_ok, vecs[i].e_iok);
      chk($sformatf("v%0d dresp_data_ok", i), dresp_data_ok, vecs[i].e_dok);
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d mreq_size", i), mreq_size, (vecs[i].e_ma == D_ADDR) ? 3'd3 : 3'd2);
        chk($sformatf("v%0d mreq_strobe", i), mreq_strobe, (vecs[i].e_ma == D_ADDR) ? 8'hFF : 8'h00);
        chk($sformatf("v%0d mreq_data", i), mreq_data, (vecs[i].e_ma == D_ADDR) ? 64'hDEAD : 64'h0);
      end
      if (vecs[i].e_iok) chk($sformatf("v%0d iresp_data", i), iresp_data, vecs[i].e_id);
      if (vecs[i].e_dok) chk($sformatf("v%0d dresp_data", i), dresp_data, vecs[i].e_dd);
    end

    // asynchronous reset in the middle of a data transaction
    @(negedge clk);
    dreq_valid = 1; dreq_addr = 64'h8000_2000; mresp_ready = 0;
    @(posedge clk);
    #1;
    chk("midrst granted", mreq_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst mreq_valid", mreq_valid, 0);
    chk("midrst dresp_data_ok", dresp_data_ok, 0);
    chk("midrst mreq_addr", mreq_addr, 0);
    @(negedge clk);
    reset = 1'b0; dreq_valid = 0; dreq_addr = D_ADDR;
    ireq_valid = 1; ireq_addr = 64'h8000_0030;
    @(posedge clk);
    #1;
    chk("postrst fetch grant", mreq_valid, 1);
    chk("postrst fetch addr", mreq_addr, 64'h8000_0030);
    @(negedge clk);
    mresp_ready = 1; mresp_data = 64'h0BAD_F00D_1234_5678;
    @(posedge clk);
    #1;
    chk("postrst iresp_data_ok", iresp_data_ok, 1);
    chk("postrst iresp_data", iresp_data, 32'h1234_5678);

    // both requesters held: record grant order with a one-cycle memory responder
    @(negedge clk);
    ireq_valid = 0; mresp_ready = 0;
    @(negedge clk);
    ireq_valid = 1; ireq_addr = 64'h8000_0040;
    dreq_valid = 1; dreq_addr = 64'h8000_3000;
    grants = 0;
    prev_v = 1'b0;
    for (int c = 0; c < 200 && grants < 6; c++) begin
      @(posedge clk);
      #1;
      if (mreq_valid && !prev_v) begin
        order_d[grants] = (mreq_addr == 64'h8000_3000);
        grants++;
      end
      prev_v = mreq_valid;
      @(negedge clk);
      mresp_ready = mreq_valid;
      mresp_data  = 64'h4242_4242_4242_4242;
    end
    mresp_ready = 0; ireq_valid = 0; dreq_valid = 0;
    chk("starve grant count", 64'(grants), 64'd6);
`ifdef MEM_ARB_STARVE_EN
    exp_d = '{1, 1, 1, 1, 0, 1};
`else
    exp_d = '{1, 1, 1, 1, 1, 1};
`endif
    for (int g = 0; g < grants; g++)
      chk($sformatf("grant %0d is data", g), order_d[g], exp_d[g]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
